// File: rtl/audio_send.sv
// Serial audio DAC sender: buffers up to two samples and shifts one word per
// aud_lrc half-frame out on aud_dacdat, MSB first, timed to the codec bit clock.
module audio_send #(
  parameter logic [5:0] WL = 6'd32
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  input  logic [31:0] dac_data,
  input  logic        dac_valid,
  output logic        dac_ready,
  output logic        aud_dacdat,
  output logic        tx_done,
  output logic        tx_chan,
  output logic        underrun
);

  logic          lrc_d0;
  logic          lrc_edge;
  logic [WL-1:0] fifo_mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;
  logic [WL-1:0] shreg;
  logic [5:0]    tx_cnt;
  logic          active;

  // Handshake: a sample transfers on any rising edge where dac_valid and
  // dac_ready are both high; dac_ready depends only on the FIFO count.
  assign lrc_edge  = aud_lrc ^ lrc_d0;
  assign dac_ready = (count != 2'd2);
  assign push      = dac_valid && dac_ready;
  // An empty FIFO is never popped, even if a push lands on the same edge.
  assign pop       = lrc_edge && (count != 2'd0);
  assign active    = (tx_cnt < WL);

  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      lrc_d0 <= 1'b0;
    end else begin
      lrc_d0 <= aud_lrc;
    end
  end

  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dac_data[WL-1:0];
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A frame edge always restarts the word, truncating any word still in flight.
  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      tx_cnt   <= WL;
      tx_chan  <= 1'b0;
      tx_done  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      underrun <= 1'b0;
      if (lrc_edge) begin
        tx_cnt  <= 6'd0;
        tx_chan <= aud_lrc;
        if (count != 2'd0) begin
          shreg <= fifo_mem[rd_ptr];
        end else begin
          shreg    <= '0;
          underrun <= 1'b1;
        end
      end else if (active) begin
        shreg   <= shreg << 1;
        tx_cnt  <= tx_cnt + 6'd1;
        tx_done <= (tx_cnt == WL - 6'd1);
      end
    end
  end

  // Data launches on the falling edge so the codec samples it mid-bit.
  always_ff @(negedge aud_bclk or posedge rst) begin
    if (rst) begin
      aud_dacdat <= 1'b0;
    end else begin
      aud_dacdat <= active ? shreg[WL-1] : 1'b0;
    end
  end

endmodule

// File: doc/audio_send.md
AUDIO_SEND -- requirements
Module: audio_send

Interface
REQ-001 SHALL have parameter WL, default 6'd32, meaning serial word length in bits (legal 1..32).
REQ-002 SHALL have port aud_bclk  input  1  codec bit clock, sole clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port aud_lrc  input  1  codec left/right frame clock, codec-mastered, changes on falling aud_bclk.
REQ-005 SHALL have port dac_data  input  32  sample word, payload in dac_data[WL-1:0].
REQ-006 SHALL have port dac_valid  input  1  dac_data holds a sample to enqueue.
REQ-007 SHALL have port dac_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port aud_dacdat  output  1  serial data to codec, MSB first.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse after the last bit of a word is driven.
REQ-010 SHALL have port tx_chan  output  1  aud_lrc value latched at the start of the current word.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse when a word starts with the buffer empty.

Function
REQ-012 SHALL register aud_lrc into lrc_d0 on rising aud_bclk; lrc_edge = aud_lrc XOR lrc_d0.
REQ-013 SHALL hold a 2-entry FIFO of WL-bit samples; dac_ready = FIFO not full (combinational from count).
REQ-014 SHALL push dac_data[WL-1:0] on a rising edge with dac_valid && dac_ready; dac_data[31:WL] ignored.
REQ-015 SHALL, on a rising edge with lrc_edge, pop the FIFO head into a WL-bit shift register, set tx_cnt to 0, latch aud_lrc into tx_chan.
REQ-016 SHALL, on lrc_edge with FIFO empty, load all zeros into the shift register and pulse underrun for that cycle.
REQ-017 SHALL allow push and pop in the same cycle: count unchanged if count==1; pop-then-push order if count==2 is impossible (ready low), count==0 push-and-edge -> pushed word not popped (underrun wins, word stays queued).
REQ-018 SHALL, on rising edges without lrc_edge and tx_cnt < WL, shift the register left by one (zero fill) and increment tx_cnt; tx_cnt saturates at WL (6-bit).
REQ-019 SHALL update aud_dacdat on falling aud_bclk: shift register MSB while tx_cnt < WL, else 0.
REQ-020 SHALL therefore drive word bit WL-1 in the half-cycle after the edge-detecting rising edge, bit WL-1-n after n further rising edges.
REQ-021 SHALL pulse tx_done high for exactly one cycle on the rising edge where tx_cnt goes WL-1 -> WL.
REQ-022 SHALL treat an lrc_edge arriving while tx_cnt < WL (short frame) as a restart: current word truncated, no tx_done, new word loaded per REQ-015/016.
REQ-023 SHALL not change FIFO content or count other than by REQ-014/015.

Reset
REQ-024 SHALL, while rst is high, asynchronously force: lrc_d0=0, FIFO count=0, shift register=0, tx_cnt=WL, aud_dacdat=0, tx_done=0, tx_chan=0, underrun=0; dac_ready=1.
REQ-025 SHALL, after rst deasserts mid-word, output zeros until the next lrc_edge; no underrun until then.
REQ-026 SHALL discard FIFO content on reset; no pulse outputs asserted on the first cycle after release.

Verification
REQ-027 SHALL verify: WL=32, push 0xA5A5_0F0F then toggle aud_lrc 0->1 -> aud_dacdat shows 1010_0101_1010_0101_0000_1111_0000_1111 on successive falling edges, tx_chan=1, tx_done one pulse 32 rising edges after load.
REQ-028 SHALL verify: push two words with lrc static -> dac_ready low after second push, third dac_valid not accepted; after one lrc_edge dac_ready returns to 1.
REQ-029 SHALL verify: lrc_edge with FIFO empty -> underrun one pulse, 32 zero bits, tx_done still pulses.
REQ-030 SHALL verify: WL=16, dac_data=0xFFFF_1234 -> bits 0001_0010_0011_0100 then zeros until next edge; tx_done at 16th rising edge.
REQ-031 SHALL verify: lrc toggles after 20 bits (WL=32) -> no tx_done, next word starts MSB on next falling edge.
REQ-032 SHALL verify: rst asserted mid-word with FIFO count=2 -> all outputs at reset values immediately, dac_ready=1, aud_dacdat 0 until next lrc_edge, which reports underrun.
